// File: rtl/aemb2_pkg.sv
// Shared AEMB2 branch-sequencer types: per-thread FSM encoding and wrong-path depth.
package aemb2_pkg;

    typedef enum logic [1:0] {
        RUN = 2'd0,
        DLY = 2'd1,
        KIL = 2'd2
    } brsState_t;

    localparam int unsigned KCNT_W = 2;

    // Same-thread instructions queued behind EX: one when interleaved, two when single-threaded.
    function automatic logic [KCNT_W-1:0] kdepOf(input int unsigned htx);
        return (htx != 0) ? KCNT_W'(1) : KCNT_W'(2);
    endfunction

endpackage

// File: rtl/aemb2_brsq_thd.sv
// Per-thread branch FSM: tracks delay slot and wrong-path kill count for one thread.
module aemb2_brsq_thd
    import aemb2_pkg::*;
#(
    parameter logic [KCNT_W-1:0] KDEP = KCNT_W'(1)
) (
    input  logic gclk,
    input  logic grst,
    input  logic ena,
    input  logic braTkn,
    input  logic braDly,
    output logic kill_c,
    output logic busy_c,
    output logic take_c
);

    brsState_t         state, stNxt;
    logic [KCNT_W-1:0] kcnt, kcntNxt;

    always_ff @(posedge gclk) begin
        if (grst) begin
            state <= RUN;
            kcnt  <= '0;
        end else if (ena) begin
            state <= stNxt;
            kcnt  <= kcntNxt;
        end
    end

    always_comb begin
        stNxt   = state;
        kcntNxt = kcnt;
        case (state)
            RUN: begin
                if (braTkn) begin
                    if (braDly) begin
                        stNxt = DLY;
                    end else begin
                        stNxt   = KIL;
                        kcntNxt = KDEP;
                    end
                end
            end
            DLY: begin
                // Delay-slot branches are dropped; only the remaining wrong-path depth matters.
                if (KDEP == KCNT_W'(2)) begin
                    stNxt   = KIL;
                    kcntNxt = KCNT_W'(1);
                end else begin
                    stNxt = RUN;
                end
            end
            KIL: begin
                kcntNxt = kcnt - KCNT_W'(1);
                if (kcntNxt == '0) stNxt = RUN;
            end
            default: begin
                stNxt   = RUN;
                kcntNxt = '0;
            end
        endcase
    end

    always_comb begin
        kill_c = (state == KIL);
        busy_c = (state != RUN);
        take_c = (state == RUN) && braTkn;
    end

endmodule

// File: rtl/aemb2_brsq.sv
// AEMB2 branch sequencer: per-thread branch FSMs, EX squash and one-shot fetch redirect.
module aemb2_brsq
    import aemb2_pkg::*;
#(
    parameter int unsigned AEMB_HTX = 1
) (
    input  logic        gclk,
    input  logic        grst,
    input  logic        dena,
    input  logic        gpha,
    input  logic [1:0]  bra_ex,
    input  logic [29:0] bra_tgt,
    output logic        kill_ex,
    output logic        bpc_ld,
    output logic        bpc_tid,
    output logic [29:0] bpc_tgt,
    output logic [1:0]  brs_busy
);

    localparam int                NTHD = (AEMB_HTX != 0) ? 2 : 1;
    localparam logic [KCNT_W-1:0] KDEP = kdepOf(AEMB_HTX);

    logic       thdSel;
    logic [1:0] killV, busyV, takeV;

    assign thdSel = (AEMB_HTX != 0) ? gpha : 1'b0;

    for (genvar gi = 0; gi < 2; gi++) begin : gThd
        if (gi < NTHD) begin : gOn
            aemb2_brsq_thd #(.KDEP(KDEP)) uThd (
                .gclk   (gclk),
                .grst   (grst),
                .ena    (dena && (thdSel == 1'(gi))),
                .braTkn (bra_ex[1]),
                .braDly (bra_ex[0]),
                .kill_c (killV[gi]),
                .busy_c (busyV[gi]),
                .take_c (takeV[gi])
            );
        end else begin : gOff
            assign killV[gi] = 1'b0;
            assign busyV[gi] = 1'b0;
            assign takeV[gi] = 1'b0;
        end
    end

    assign kill_ex  = killV[thdSel];
    assign brs_busy = busyV;

    // Redirect register: a new redirect from either thread overrides the clearing of the old one.
    always_ff @(posedge gclk) begin
        if (grst) begin
            bpc_ld  <= 1'b0;
            bpc_tid <= 1'b0;
            bpc_tgt <= '0;
        end else if (dena) begin
            if (takeV[thdSel]) begin
                bpc_ld  <= 1'b1;
                bpc_tid <= thdSel;
                bpc_tgt <= bra_tgt;
            end else begin
                bpc_ld  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/aemb2_brsq.md
# aemb2_brsq

Branch sequencer for the AEMB2 pipeline. It consumes the registered branch/delay decision from the branch condition checker, together with the ALU-computed target. It tracks per-thread branch state across the interleaved thread phases and issues a one-shot PC redirect to fetch. It squashes wrong-path instructions in EX and suppresses nested branches in delay slots.

## Interface

**Parameters**
- `AEMB_HTX`, default 1. 1 = two hardware threads interleaved by `gpha`; 0 = single thread, `gpha` ignored, thread 0 only.

**Ports**
- `gclk`  in  1  core clock; all state updates on its rising edge.
- `grst`  in  1  reset. Synchronous and active-high.
- `dena`  in  1  pipeline advance; when low, all state and outputs hold.
- `gpha`  in  1  thread ID of the instruction currently in EX.
- `bra_ex`  in  2  [1] = branch taken, [0] = has delay slot; valid for the EX instruction.
- `bra_tgt`  in  30  branch target word address [31:2] from ALU, valid with `bra_ex`.
- `kill_ex`  out  1  squash the EX instruction: no writeback, no memory op, its `bra_ex` ignored.
- `bpc_ld`  out  1  fetch must load `bpc_tgt` into the PC of thread `bpc_tid`.
- `bpc_tid`  out  1  thread to redirect.
- `bpc_tgt`  out  30  redirect target.
- `brs_busy`  out  2  per-thread flag: thread not in RUN.

## Operation

- One FSM per thread (two when `AEMB_HTX`=1, one otherwise). Only the FSM of thread `t = AEMB_HTX ? gpha : 0` evaluates in a given cycle.
- Wrong-path depth `KDEP`: 1 when `AEMB_HTX`=1, 2 when `AEMB_HTX`=0. This is the number of same-thread instructions behind EX.
- **RUN**
  - If `bra_ex[1]` and not `kill_ex`, capture `bra_tgt` and schedule a redirect.
  - If `bra_ex[0]`=1: go to DLY.
  - Else, if `KDEP`>0: go to KIL with `kcnt=KDEP`.
- **DLY**
  - The next instruction of the thread executes normally.
  - Its `bra_ex[1]` is ignored; a branch in a delay slot is unsupported and is dropped.
  - If `KDEP`=2, go to KIL with `kcnt=1`; else go to RUN.
- **KIL**
  - `kill_ex`=1 for each EX instruction of this thread.
  - Decrement `kcnt`; at 0, go to RUN.
- `kill_ex` is combinational: (state[t]==KIL).
- Redirect register:
  - `bpc_ld`, `bpc_tid`, `bpc_tgt` load on the dena-edge that accepts a taken branch.
  - `bpc_ld` clears on the next dena-edge with no new redirect.
- Simultaneous events: a redirect from the other thread on the edge `bpc_ld` clears replaces it; `bpc_ld` stays 1 with the new tid/tgt.
- Reset values: all FSMs RUN, `kcnt`=0, `bpc_ld`=0, `bpc_tid`=0, `bpc_tgt`=0, `kill_ex`=0, `brs_busy`=0.

## Timing

- Decision-to-redirect latency: 1 dena-edge. `bpc_ld` is high in the cycle after `bra_ex[1]` is sampled.
- While `dena`=0:
  - FSM states, `kcnt` and the redirect register are frozen.
  - `kill_ex` keeps its value, since it is derived from frozen state and `gpha`.
- `grst` mid-branch, in any state: RUN on the next edge. A pending `bpc_ld` is dropped; fetch restarts from its own reset vector.
- `bra_ex` with `bra_ex[1]`=0: `bra_ex[0]` is don't-care; no state change.
- `bra_tgt` bits are stored verbatim; no arithmetic in this block.

## Structure

- Shared package `aemb2_pkg`:
  - FSM state encoding: RUN=2'd0, DLY=2'd1, KIL=2'd2.
  - `KDEP` function of `AEMB_HTX`.
- Natural sub-module `aemb2_brsq_thd`: one per-thread FSM plus `kcnt`, instantiated 1 or 2 times.
- Top-level logic: thread select, redirect register, output muxing.

## Test plan

- **Taken, no delay, HTX=1:** thread 0 EX `bra_ex`=2'b10, `bra_tgt`=30'h100.
  - Next cycle: `bpc_ld`=1, `bpc_tid`=0, `bpc_tgt`=30'h100.
  - Next thread-0 EX: `kill_ex`=1. Following thread-0 EX: `kill_ex`=0.
- **Taken with delay, HTX=1:** thread 1 `bra_ex`=2'b11, `bra_tgt`=30'h2A.
  - `bpc_ld`=1, `bpc_tid`=1.
  - Next thread-1 EX: `kill_ex`=0. A branch there with `bra_ex`=2'b10 is ignored: no second `bpc_ld`.
- **Single thread, HTX=0:** `bra_ex`=2'b10. The next two EX instructions have `kill_ex`=1, then 0. With `bra_ex`=2'b11: one clean, one killed.
- **Stall:** `dena`=0 for 3 cycles while thread 0 is in KIL. `kill_ex` and `bpc_ld` hold; the kill count completes only after `dena` returns.
- **Back-to-back threads:** thread 0 taken to 30'h10, then thread 1 taken to 30'h20 on the next edge. `bpc_ld` stays 1: first tid0/30'h10, then tid1/30'h20.
- **Reset mid-op:** assert `grst` while thread 0 is in KIL and `bpc_ld`=1. Next edge: all outputs 0, `brs_busy`=2'b00.
